// File: rtl/pinca_pkg.sv
// Shared pipeline constants, fetch FSM encoding and the fetch payload type.
package pinca_pkg;

    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_PC  = '0;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        BEAT    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} skid buffer that absorbs the word fetched while decode is stalled.
module fetch_skid_buf
    import pinca_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_flush,
    input  fetch_word_t i_data,
    output logic        o_full,
    output fetch_word_t o_data
);

    logic        r_full;
    fetch_word_t r_data;

    // Flush wins over everything; a load always leaves the entry occupied.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, multi-beat fetch FSM on the controller port, and if_id output registers.
module instr_fetch
    import pinca_pkg::*;
#(
    parameter int unsigned PC_STEP       = 4,
    parameter int unsigned ACCESS_CYCLES = 2
)(
    input  logic               clock,
    input  logic               reset,
    output logic               if_mc_en,
    output logic [ADDR_W-1:0]  if_mc_addr,
    input  logic [INSTR_W-1:0] mc_if_data,
    input  logic               mem_mc_en,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid
);

    localparam int unsigned BEAT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    fetch_state_t       r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_mc_en;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_id_pc;
    logic               r_valid;

    logic               w_capture;
    logic               w_out_free;
    logic               w_buf_load;
    logic               w_buf_drain;
    logic               w_buf_full;
    fetch_word_t        w_fetched;
    fetch_word_t        w_buf_data;

    assign w_capture   = (r_state == CAPTURE);
    assign w_out_free  = !r_valid || !stall;
    assign w_fetched   = '{instr: mc_if_data, pc: r_pc};
    assign w_buf_load  = w_capture && !w_out_free && !branch_taken;
    assign w_buf_drain = !w_capture && w_buf_full && w_out_free && !branch_taken;

    fetch_skid_buf u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_buf_load),
        .i_drain (w_buf_drain),
        .i_flush (branch_taken),
        .i_data  (w_fetched),
        .o_full  (w_buf_full),
        .o_data  (w_buf_data)
    );

    // Branch redirect overrides the FSM and output path; otherwise outputs and FSM advance together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ISSUE;
            r_beat  <= '0;
            r_pc    <= RESET_PC;
            r_mc_en <= 1'b0;
            r_instr <= NOP_INSTR;
            r_id_pc <= '0;
            r_valid <= 1'b0;
        end else if (branch_taken) begin
            r_state <= ISSUE;
            r_beat  <= '0;
            r_pc    <= branch_target & ~ADDR_W'(3);
            r_mc_en <= 1'b1;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else begin
            if (w_capture && w_out_free) begin
                r_instr <= w_fetched.instr;
                r_id_pc <= w_fetched.pc;
                r_valid <= 1'b1;
            end else if (w_buf_drain) begin
                r_instr <= w_buf_data.instr;
                r_id_pc <= w_buf_data.pc;
                r_valid <= 1'b1;
            end else if (!stall) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ISSUE: begin
                    r_beat  <= '0;
                    r_mc_en <= 1'b1;
                    if (!mem_mc_en) r_state <= BEAT;
                end
                // A memory-stage access aborts the word; it restarts from the first beat.
                BEAT: begin
                    if (mem_mc_en) begin
                        r_state <= ISSUE;
                        r_beat  <= '0;
                    end else if (r_beat == BEAT_W'(ACCESS_CYCLES - 1)) begin
                        r_state <= CAPTURE;
                        r_mc_en <= 1'b0;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                CAPTURE: begin
                    r_pc <= r_pc + ADDR_W'(PC_STEP);
                    if (w_buf_load) begin
                        r_state <= HOLD;
                        r_mc_en <= 1'b0;
                    end else begin
                        r_state <= ISSUE;
                        r_mc_en <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_buf_drain) begin
                        r_state <= ISSUE;
                        r_mc_en <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign if_mc_en    = r_mc_en;
    assign if_mc_addr  = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_id_pc;
    assign if_id_valid = r_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational word-addressed memory model.
module tb_instr_fetch;
    import pinca_pkg::*;

    logic               clock;
    logic               reset;
    logic               if_mc_en;
    logic [ADDR_W-1:0]  if_mc_addr;
    logic [INSTR_W-1:0] mc_if_data;
    logic               mem_mc_en;
    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc;
    logic               if_id_valid;

    int checks;
    int errors;

    instr_fetch dut (
        .clock         (clock),
        .reset         (reset),
        .if_mc_en      (if_mc_en),
        .if_mc_addr    (if_mc_addr),
        .mc_if_data    (mc_if_data),
        .mem_mc_en     (mem_mc_en),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 18'h0) return 32'hDEAD_BEEF;
        if (a == 18'h4) return 32'h1234_5678;
        return {14'h1A5, a};
    endfunction

    assign mc_if_data = mem_word(if_mc_addr);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (if_id_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_mc_en = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        tick(); tick();
        checks++; if (if_mc_en !== 1'b0) begin errors++; $display("FAIL reset_mc_en got %b exp 0", if_mc_en); end
        checks++; if (if_mc_addr !== 18'h0) begin errors++; $display("FAIL reset_mc_addr got %h exp 0", if_mc_addr); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_id_instr); end
        checks++; if (if_id_pc !== 18'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_id_pc); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    endtask

    task automatic test_basic();
        int n;
        reset = 1'b1;
        tick();
        checks++; if (if_mc_en !== 1'b1) begin errors++; $display("FAIL basic_mc_en got %b exp 1", if_mc_en); end
        tick(); tick(); tick();
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL basic_latency valid got %b exp 1", if_id_valid); end
        checks++; if (if_id_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_instr0 got %h exp deadbeef", if_id_instr); end
        checks++; if (if_id_pc !== 18'h0) begin errors++; $display("FAIL basic_pc0 got %h exp 0", if_id_pc); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble got %b exp 0", if_id_valid); end
        wait_valid(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL basic_throughput got %0d exp 3", n); end
        checks++; if (if_id_pc !== 18'h4) begin errors++; $display("FAIL basic_pc4 got %h exp 4", if_id_pc); end
        checks++; if (if_id_instr !== 32'h1234_5678) begin errors++; $display("FAIL basic_instr4 got %h exp 12345678", if_id_instr); end
    endtask

    task automatic test_mem_contention();
        int n;
        tick();
        mem_mc_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_mc_addr !== 18'h8) begin errors++; $display("FAIL contend_addr[%0d] got %h exp 8", i, if_mc_addr); end
            checks++; if (if_mc_en !== 1'b1) begin errors++; $display("FAIL contend_en[%0d] got %b exp 1", i, if_mc_en); end
        end
        mem_mc_en = 1'b0;
        wait_valid(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL contend_latency got %0d exp 4", n); end
        checks++; if (if_id_pc !== 18'h8) begin errors++; $display("FAIL contend_pc got %h exp 8", if_id_pc); end
        checks++; if (if_id_instr !== 32'h0694_0008) begin errors++; $display("FAIL contend_instr got %h exp 06940008", if_id_instr); end
    endtask

    task automatic test_stall();
        int n;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wait_valid(n);
        checks++; if (n !== 4 || if_id_pc !== 18'h0) begin errors++; $display("FAIL stall_setup n=%0d pc=%h exp 4/0", n, if_id_pc); end
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h0) begin errors++; $display("FAIL stall_hold[%0d] valid=%b pc=%h exp 1/0", i, if_id_valid, if_id_pc); end
        end
        checks++; if (if_mc_en !== 1'b0) begin errors++; $display("FAIL stall_hold_state en got %b exp 0", if_mc_en); end
        checks++; if (if_mc_addr !== 18'h8) begin errors++; $display("FAIL stall_one_fetch addr got %h exp 8", if_mc_addr); end
        stall = 1'b0;
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h4) begin errors++; $display("FAIL stall_drain valid=%b pc=%h exp 1/4", if_id_valid, if_id_pc); end
        checks++; if (if_id_instr !== 32'h1234_5678) begin errors++; $display("FAIL stall_drain_instr got %h exp 12345678", if_id_instr); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_after_drain got %b exp 0", if_id_valid); end
        wait_valid(n);
        checks++; if (n !== 3 || if_id_pc !== 18'h8) begin errors++; $display("FAIL stall_resume n=%0d pc=%h exp 3/8", n, if_id_pc); end
    endtask

    task automatic test_branch();
        int n;
        tick();
        branch_taken = 1'b1; branch_target = 18'h100;
        tick();
        branch_taken = 1'b0;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL branch_valid got %b exp 0", if_id_valid); end
        checks++; if (if_mc_addr !== 18'h100) begin errors++; $display("FAIL branch_addr got %h exp 100", if_mc_addr); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL branch_nop got %h exp 0", if_id_instr); end
        checks++; if (if_mc_en !== 1'b1) begin errors++; $display("FAIL branch_en got %b exp 1", if_mc_en); end
        wait_valid(n);
        checks++; if (n !== 4 || if_id_pc !== 18'h100) begin errors++; $display("FAIL branch_target n=%0d pc=%h exp 4/100", n, if_id_pc); end
        checks++; if (if_id_instr !== 32'h0694_0100) begin errors++; $display("FAIL branch_instr got %h exp 06940100", if_id_instr); end
        branch_taken = 1'b1; branch_target = 18'h203;
        tick();
        branch_taken = 1'b0;
        checks++; if (if_mc_addr !== 18'h200) begin errors++; $display("FAIL branch_misalign addr got %h exp 200", if_mc_addr); end
        wait_valid(n);
        checks++; if (n !== 4 || if_id_pc !== 18'h200) begin errors++; $display("FAIL branch_misalign_pc n=%0d pc=%h exp 4/200", n, if_id_pc); end
    endtask

    task automatic test_branch_capture();
        int n;
        stall = 1'b1;
        tick(); tick(); tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 18'h200) begin errors++; $display("FAIL bcap_held valid=%b pc=%h exp 1/200", if_id_valid, if_id_pc); end
        branch_taken = 1'b1; branch_target = 18'h40;
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL bcap_valid got %b exp 0", if_id_valid); end
        checks++; if (if_mc_addr !== 18'h40 || if_mc_en !== 1'b1) begin errors++; $display("FAIL bcap_addr addr=%h en=%b exp 40/1", if_mc_addr, if_mc_en); end
        wait_valid(n);
        checks++; if (n !== 4 || if_id_pc !== 18'h40) begin errors++; $display("FAIL bcap_next n=%0d pc=%h exp 4/40", n, if_id_pc); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL bcap_dropped got %b exp 0", if_id_valid); end
    endtask

    task automatic test_wrap_and_reset();
        int n;
        branch_taken = 1'b1; branch_target = 18'h3FFFC;
        tick();
        branch_taken = 1'b0;
        wait_valid(n);
        checks++; if (n !== 4 || if_id_pc !== 18'h3FFFC) begin errors++; $display("FAIL wrap_fetch n=%0d pc=%h exp 4/3fffc", n, if_id_pc); end
        checks++; if (if_id_instr !== 32'h0697_FFFC) begin errors++; $display("FAIL wrap_instr got %h exp 0697fffc", if_id_instr); end
        checks++; if (if_mc_addr !== 18'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", if_mc_addr); end
        stall = 1'b1;
        tick(); tick();
        checks++; if (if_mc_en !== 1'b1 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_midbeat en=%b valid=%b exp 1/1", if_mc_en, if_id_valid); end
        reset = 1'b0;
        #1;
        checks++; if (if_mc_en !== 1'b0) begin errors++; $display("FAIL async_en got %b exp 0", if_mc_en); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", if_id_valid); end
        checks++; if (if_id_pc !== 18'h0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL async_out pc=%h instr=%h exp 0/0", if_id_pc, if_id_instr); end
        stall = 1'b0;
        tick();
        reset = 1'b1;
        wait_valid(n);
        checks++; if (n !== 4 || if_id_pc !== 18'h0 || if_id_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL restart n=%0d pc=%h instr=%h exp 4/0/deadbeef", n, if_id_pc, if_id_instr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_mem_contention();
        test_stall();
        test_branch();
        test_branch_capture();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
